sram_fifo_ctrl: RTL and testbench

- FIFO controller that sits directly upstream of the single-port synchronous RAM (sync_ram: clk, we, addr, din, dout).
- Accepts a valid/ready write stream and generates the RAM's we/addr/din.
- Reads the RAM back in order and presents the data on a registered valid/ready output stream.
- Turns the bare 8x8 RAM into a 9-entry FIFO: 8 RAM words plus 1 output register.

---
 rtl/sram_fifo_ctrl_if.sv | 36 +++
 rtl/sram_fifo_ctrl.sv | 83 ++++++++
 tb/tb_sram_fifo_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_fifo_ctrl_if
// Brief    : Write stream, read stream and RAM-side bundle for sram_fifo_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic [ADDR_W:0]   ram_count;
  logic              full;

  // Environment side: produces the write stream, consumes the read stream, models the RAM.
  modport master (
    output s_valid, s_data, m_ready, ram_dout,
    input  s_ready, m_valid, m_data, ram_we, ram_addr, ram_din, ram_count, full
  );

  // Controller side.
  modport slave (
    input  s_valid, s_data, m_ready, ram_dout,
    output s_ready, m_valid, m_data, ram_we, ram_addr, ram_din, ram_count, full
  );
endinterface
`default_nettype wire

// File: rtl/sram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_fifo_ctrl
// Brief    : Turns a single-port sync RAM plus one output register into a
//            DEPTH+1 entry valid/ready FIFO; reads take priority over writes.
// Revision : 1.0 - initial release
// ============================================================================
module sram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  sram_fifo_ctrl_if.slave    bus
);

  localparam logic [ADDR_W:0] c_depth = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_rd_pend;
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;

  logic w_full;
  logic w_rd_issue;
  logic w_s_ready;
  logic w_wr;

  // A read is only issued when the output register is guaranteed free at capture.
  assign w_full     = (r_count == c_depth);
  assign w_rd_issue = (r_count != '0) && !r_rd_pend && (!r_m_valid || bus.m_ready);
  assign w_s_ready  = rst_n && !w_full && !w_rd_issue;
  assign w_wr       = bus.s_valid && w_s_ready;

  assign bus.s_ready   = w_s_ready;
  assign bus.ram_we    = w_wr;
  assign bus.ram_addr  = w_wr ? r_wr_ptr : r_rd_ptr;
  assign bus.ram_din   = bus.s_data;
  assign bus.ram_count = r_count;
  assign bus.full      = w_full;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_data    = r_m_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        r_count  <= r_count + (ADDR_W+1)'(1);
      end else if (w_rd_issue) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        r_count  <= r_count - (ADDR_W+1)'(1);
      end
      // Issue is never asserted while a read is pending, so this both sets and clears it.
      r_rd_pend <= w_rd_issue;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (r_rd_pend) begin
      r_m_valid <= 1'b1;
      r_m_data  <= bus.ram_dout;
    end else if (r_m_valid && bus.m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) r_count <= c_depth);
  a_full_blocks: assert property (@(posedge clk) disable iff (!rst_n) w_full |-> !w_s_ready);
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_fifo_ctrl
// Brief    : Self-checking bench: vector table, directed corner cases and a
//            per-cycle reference model with an in-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sram_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  sram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural sync RAM: samples on the edge, read data valid for the next cycle.
  logic [7:0] mem [8];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    ram_q <= mem[bus.ram_addr];
  end
  assign bus.ram_dout = ram_q;

  typedef struct {
    logic       sv;
    logic [7:0] d;
    logic       mr;
    logic       e_sready;
    logic       e_we;
    logic [2:0] e_addr;
    logic       e_mvalid;
    logic [7:0] e_mdata;
    logic [3:0] e_count;
  } vec_t;
  vec_t vecs [11];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0] sb [$];
  int         mdl_count;
  logic       mdl_pend;
  logic       mdl_mv;
  logic [2:0] mdl_wr;
  logic [2:0] mdl_rd;
  logic       hold_prev;
  logic [7:0] hold_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic clear_models();
    sb.delete();
    mdl_count = 0;
    mdl_pend  = 1'b0;
    mdl_mv    = 1'b0;
    mdl_wr    = '0;
    mdl_rd    = '0;
    hold_prev = 1'b0;
    hold_data = '0;
  endtask

  task automatic monitor();
    logic       exp_issue;
    logic       exp_sready;
    logic       exp_wr;
    logic       old_mv;
    logic [7:0] exp_d;
    if (!rst_n) return;
    exp_issue  = (mdl_count != 0) && !mdl_pend && (!mdl_mv || bus.m_ready);
    exp_sready = (mdl_count != 8) && !exp_issue;
    exp_wr     = bus.s_valid && exp_sready;
    chk("m_count", 32'(bus.ram_count), 32'(mdl_count));
    chk("m_full", 32'(bus.full), 32'(mdl_count == 8));
    chk("m_s_ready", 32'(bus.s_ready), 32'(exp_sready));
    chk("m_ram_we", 32'(bus.ram_we), 32'(exp_wr));
    chk("m_ram_addr", 32'(bus.ram_addr), 32'(exp_wr ? mdl_wr : mdl_rd));
    chk("m_ram_din", 32'(bus.ram_din), 32'(bus.s_data));
    chk("m_valid", 32'(bus.m_valid), 32'(mdl_mv));
    if (hold_prev) chk("m_hold_data", 32'(bus.m_data), 32'(hold_data));
    if (mdl_mv && bus.m_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        exp_d = sb.pop_front();
        chk("sb_order", 32'(bus.m_data), 32'(exp_d));
      end
    end
    if (exp_wr) sb.push_back(bus.s_data);
    if (exp_wr) begin
      mdl_wr++;
      mdl_count++;
    end else if (exp_issue) begin
      mdl_rd++;
      mdl_count--;
    end
    old_mv    = mdl_mv;
    hold_prev = old_mv && !bus.m_ready;
    hold_data = bus.m_data;
    if (mdl_pend) mdl_mv = 1'b1;
    else if (old_mv && bus.m_ready) mdl_mv = 1'b0;
    mdl_pend = exp_issue;
  endtask

  // Inputs are driven at posedge+1; the model runs at the negedge.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bit ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = bus.s_ready;
      cycle();
    end
    bus.s_valid = 1'b0;
    if (!ok) chk("push_timeout", 32'(ok), 32'd1);
  endtask

  task automatic stream(input int n, input logic [7:0] base, input bit toggle);
    int sent = 0;
    bus.s_valid = 1'b1;
    for (int cyc = 0; cyc < 400 && sent < n; cyc++) begin
      bus.s_data  = base + 8'(sent);
      bus.m_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      #1;
      if (bus.s_ready) sent++;
      cycle();
    end
    bus.s_valid = 1'b0;
    chk("stream_sent", 32'(sent), 32'(n));
  endtask

  task automatic drain(input int n);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    repeat (n) cycle();
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_count", 32'(bus.ram_count), 32'd0);
    chk("drain_m_valid", 32'(bus.m_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_async_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_async_count", 32'(bus.ram_count), 32'd0);
    chk("rst_async_s_ready", 32'(bus.s_ready), 32'd0);
    clear_models();
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00, 4'd0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 4'd1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00, 4'd0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 8'hAA, 4'd0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 8'hAA, 4'd0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 8'hAA, 4'd0};
    vecs[6]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'h00, 4'd0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 8'h00, 4'd1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 8'h00, 4'd0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 8'h3C, 4'd0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 8'h00, 4'd0};

    clear_models();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h77;
    bus.m_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rel_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rel_count", 32'(bus.ram_count), 32'd0);
    chk("rel_full", 32'(bus.full), 32'd0);
    chk("rel_ram_we", 32'(bus.ram_we), 32'd0);
    cycle();

    // Single-word latency and hold behaviour
    for (int i = 0; i < 11; i++) begin
      bus.s_valid = vecs[i].sv;
      bus.s_data  = vecs[i].d;
      bus.m_ready = vecs[i].mr;
      #1;
      chk($sformatf("vec%0d_s_ready", i), 32'(bus.s_ready), 32'(vecs[i].e_sready));
      chk($sformatf("vec%0d_ram_we", i), 32'(bus.ram_we), 32'(vecs[i].e_we));
      chk($sformatf("vec%0d_ram_addr", i), 32'(bus.ram_addr), 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d_m_valid", i), 32'(bus.m_valid), 32'(vecs[i].e_mvalid));
      chk($sformatf("vec%0d_count", i), 32'(bus.ram_count), 32'(vecs[i].e_count));
      if (vecs[i].e_mvalid)
        chk($sformatf("vec%0d_m_data", i), 32'(bus.m_data), 32'(vecs[i].e_mdata));
      if (vecs[i].e_we)
        chk($sformatf("vec%0d_ram_din", i), 32'(bus.ram_din), 32'(vecs[i].d));
      cycle();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;

    // Fill to capacity with the sink stalled
    push(8'hAA);
    push(8'h55);
    push(8'hF0);
    for (int k = 1; k <= 6; k++) push(8'(k));
    cycle();
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.ram_count), 32'd8);
    chk("fill_m_valid", 32'(bus.m_valid), 32'd1);
    chk("fill_m_data", 32'(bus.m_data), 32'hAA);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h99;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fill_reject_s_ready", 32'(bus.s_ready), 32'd0);
      cycle();
    end
    drain(30);

    // Continuous streaming across pointer wrap
    stream(24, 8'h00, 1'b0);
    drain(20);

    // Reset with data held in the output register and the RAM
    bus.m_ready = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (2) cycle();
    chk("pre_rst_m_valid", 32'(bus.m_valid), 32'd1);
    pulse_reset();

    // Reset with a read in flight
    bus.m_ready = 1'b1;
    push(8'h44);
    cycle();
    pulse_reset();
    repeat (5) cycle();
    chk("post_rst_no_ghost", 32'(bus.m_valid), 32'd0);
    push(8'h55);
    begin
      bit got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        if (bus.m_valid) got = 1'b1;
        else cycle();
      end
      chk("post_rst_valid_seen", 32'(got), 32'd1);
      chk("post_rst_m_data", 32'(bus.m_data), 32'h55);
      cycle();
    end

    // Toggling sink against a steady source
    stream(40, 8'h40, 1'b1);
    drain(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
